mux41: RTL and testbench

Registered 4-to-1 selector: one of four data inputs, chosen by a 2-bit select, is captured into an output register on each enabled clock edge. It is a leaf datapath block used wherever a clocked, glitch-free selection among four equal-width sources is needed. The select-to-input mapping is S=00→D1, 01→D2, 10→D3, 11→D4. A valid flag and the captured select index accompany the data.

---
 rtl/mux41.sv | 60 ++++++
 tb/tb_mux41.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux41.sv
// Registered 4-to-1 selector: one of four WIDTH-bit sources, chosen by S,
// is captured with its select index and a valid flag on each enabled edge.
module mux41 #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic [WIDTH-1:0] D4,
  output logic [WIDTH-1:0] Y,
  output logic             Y_valid,
  output logic [1:0]       S_q
);

  logic [WIDTH-1:0] sel;

  // NOTE: the default arm makes the case full, so no latch can be inferred.
  always_comb begin
    case (S)
      2'b00:   sel = D1;
      2'b01:   sel = D2;
      2'b10:   sel = D3;
      default: sel = D4;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and overrides en.
  always_ff @(posedge clk) begin
    if (rst) begin
      S_q     <= 2'b00;
      Y_valid <= 1'b0;
    end else if (en) begin
      S_q     <= S;
      Y_valid <= 1'b1;
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic [WIDTH-1:0] y_q;

      always_ff @(posedge clk) begin
        if (rst)     y_q <= '0;
        else if (en) y_q <= sel;
      end

      assign Y = y_q;
    end else begin : g_comb_out
      // Combinational data path; only the side-band flags stay registered.
      assign Y = sel;
    end
  endgenerate

endmodule

// File: tb/tb_mux41.sv
// Self-checking bench for mux41: registered 8-bit, registered 1-bit and
// combinational 8-bit instances compared against an index-based model.
module tb_mux41;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] s;
  logic [7:0] d [4];

  logic [7:0] y8, yc;
  logic [0:0] y1;
  logic       v8, v1, vc;
  logic [1:0] sq8, sq1, sqc;

  int checks = 0;
  int errors = 0;

  // Model state: what the registered outputs should hold after the last edge.
  logic [7:0] m_y;
  logic [1:0] m_sq;
  logic       m_v;

  always #5 clk = ~clk;

  mux41 #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (
    .clk(clk), .rst(rst), .en(en), .S(s),
    .D1(d[0]), .D2(d[1]), .D3(d[2]), .D4(d[3]),
    .Y(y8), .Y_valid(v8), .S_q(sq8)
  );

  mux41 dut1 (
    .clk(clk), .rst(rst), .en(en), .S(s),
    .D1(d[0][0]), .D2(d[1][0]), .D3(d[2][0]), .D4(d[3][0]),
    .Y(y1), .Y_valid(v1), .S_q(sq1)
  );

  mux41 #(.WIDTH(8), .REG_OUT(1'b0)) dutc (
    .clk(clk), .rst(rst), .en(en), .S(s),
    .D1(d[0]), .D2(d[1]), .D3(d[2]), .D4(d[3]),
    .Y(yc), .Y_valid(vc), .S_q(sqc)
  );

  // Advance one rising edge, updating the model from the inputs at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_y = 8'h00; m_sq = 2'b00; m_v = 1'b0;
    end else if (en) begin
      m_y = d[s]; m_sq = s; m_v = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; s = 2'b11;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'hFF;
    tick(); tick();
    checks++;
    if ({y8, sq8, v8, y1, sq1, v1, sqc, vc} !== {8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset_values y8=%h sq8=%b v8=%b y1=%b sq1=%b v1=%b sqc=%b vc=%b required all zero",
               y8, sq8, v8, y1, sq1, v1, sqc, vc);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({y8, sq8, v8, y1, v1} !== {8'hFF, 2'b11, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_release y8=%h sq8=%b v8=%b y1=%b v1=%b required ff 11 1 1 1",
               y8, sq8, v8, y1, v1);
    end
    // Raising rst between edges must not disturb the outputs yet.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({y8, v8, vc} !== {8'hFF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_sync y8=%h v8=%b vc=%b required ff 1 1", y8, v8, vc);
    end
    tick();
    checks++;
    if ({y8, sq8, v8, vc} !== {8'h00, 2'b00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_edge y8=%h sq8=%b v8=%b vc=%b required 00 00 0 0", y8, sq8, v8, vc);
    end
    rst = 1'b0;
  endtask

  task automatic test_select_sweep();
    d[0] = 8'h00; d[1] = 8'h01; d[2] = 8'h00; d[3] = 8'h01; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = i[1:0];
      for (int k = 0; k < 2; k++) begin
        tick();
        checks++;
        if ({y8, sq8, v8, y1, sq1} !== {m_y, m_sq, 1'b1, m_y[0], m_sq} || y1 !== i[0]) begin
          errors++;
          $display("FAIL select_sweep s=%0d y8=%h sq8=%b v8=%b y1=%b required y=%h sq=%b y1=%b",
                   i, y8, sq8, v8, y1, m_y, m_sq, i[0]);
        end
      end
    end
  endtask

  task automatic test_hold();
    s = 2'b01; d[1] = 8'h01; en = 1'b1;
    tick();
    en = 1'b0; s = 2'b10; d[1] = 8'h00; d[2] = 8'hC3;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({y8, sq8, v8, y1, sqc, vc} !== {8'h01, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1}) begin
        errors++;
        $display("FAIL hold y8=%h sq8=%b v8=%b y1=%b sqc=%b required 01 01 1 1 01",
                 y8, sq8, v8, y1, sqc);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if ({y8, sq8} !== {8'hC3, 2'b10}) begin
      errors++;
      $display("FAIL hold_release y8=%h sq8=%b required c3 10", y8, sq8);
    end
  endtask

  task automatic test_data_tracking();
    s = 2'b10; en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d[2] = {7'h00, k[0]};
      d[0] = 8'($urandom); d[1] = 8'($urandom); d[3] = 8'($urandom);
      tick();
      checks++;
      if ({y8, y1} !== {{7'h00, k[0]}, k[0]} || y8 !== m_y) begin
        errors++;
        $display("FAIL data_tracking k=%0d y8=%h y1=%b required %h %b", k, y8, y1, m_y, k[0]);
      end
    end
  endtask

  task automatic test_wide();
    logic [7:0] exp [4];
    exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'hFF; exp[3] = 8'h00;
    d[0] = 8'hA5; d[1] = 8'h3C; d[2] = 8'hFF; d[3] = 8'h00; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = i[1:0];
      tick();
      checks++;
      if (y8 !== exp[i] || sq8 !== i[1:0]) begin
        errors++;
        $display("FAIL wide s=%0d y8=%h sq8=%b required %h %b", i, y8, sq8, exp[i], i[1:0]);
      end
    end
  endtask

  task automatic test_comb();
    rst = 1'b1; en = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0; s = 2'b11; d[3] = 8'h01;
    #1;
    checks++;
    if ({yc, vc} !== {8'h01, 1'b0}) begin
      errors++;
      $display("FAIL comb_same_cycle yc=%h vc=%b required 01 0", yc, vc);
    end
    d[3] = 8'h5A; s = 2'b11;
    #1;
    checks++;
    if (yc !== 8'h5A) begin
      errors++;
      $display("FAIL comb_no_en yc=%h required 5a", yc);
    end
    en = 1'b1;
    tick();
    checks++;
    if ({yc, vc, sqc} !== {8'h5A, 1'b1, 2'b11}) begin
      errors++;
      $display("FAIL comb_valid yc=%h vc=%b sqc=%b required 5a 1 11", yc, vc, sqc);
    end
    // Y must follow the mux even while reset is held.
    rst = 1'b1; s = 2'b00; d[0] = 8'h9C;
    #1;
    checks++;
    if (yc !== 8'h9C) begin
      errors++;
      $display("FAIL comb_in_reset yc=%h required 9c", yc);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 19) == 0);
      en  = ($urandom_range(0, 3) != 0);
      s   = 2'($urandom);
      for (int j = 0; j < 4; j++) d[j] = 8'($urandom);
      #1;
      checks++;
      if (yc !== d[s]) begin
        errors++;
        $display("FAIL random_comb k=%0d yc=%h required %h", k, yc, d[s]);
      end
      tick();
      checks++;
      if ({y8, sq8, v8, y1, sq1, v1, sqc, vc} !== {m_y, m_sq, m_v, m_y[0], m_sq, m_v, m_sq, m_v}) begin
        errors++;
        $display("FAIL random_reg k=%0d y8=%h sq8=%b v8=%b y1=%b sqc=%b vc=%b required %h %b %b",
                 k, y8, sq8, v8, y1, sqc, vc, m_y, m_sq, m_v);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s = 2'b00;
    for (int j = 0; j < 4; j++) d[j] = 8'h00;
    m_y = 8'h00; m_sq = 2'b00; m_v = 1'b0;
    #2;
    test_reset();
    test_select_sweep();
    test_hold();
    test_data_tracking();
    test_wide();
    test_comb();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
